// File: rtl/pe_pkg.sv
// Shared types and helpers for the parametrised MAC processing element.
package pe_pkg;

  typedef enum logic {IDLE, ACC} state_t;

  // Largest representable accumulator value as a 64-bit pattern (aw <= 63).
  function automatic logic [63:0] sat_max(input int unsigned aw, input bit sgn);
    return sgn ? ((64'd1 << (aw - 1)) - 64'd1) : ((64'd1 << aw) - 64'd1);
  endfunction

  // Smallest representable accumulator value as a 64-bit two's-complement pattern.
  function automatic logic [63:0] sat_min(input int unsigned aw, input bit sgn);
    return sgn ? ~((64'd1 << (aw - 1)) - 64'd1) : 64'd0;
  endfunction

  // Sign- or zero-extend the low pw bits of prod to 64 bits.
  function automatic logic [63:0] ext_prod(input logic [63:0] prod, input int unsigned pw,
                                           input bit sgn);
    logic [63:0] hi;
    hi = ~64'd0 << pw;
    if (sgn && prod[pw-1]) return prod | hi;
    return prod & ~hi;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational extend-multiply-add-clamp datapath for one MAC step.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 32,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b1
) (
  input  logic [AW-1:0] acc,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] a,
  input  logic          clear,
  output logic [AW-1:0] next_acc,
  output logic          clamped
);

  localparam logic [AW-1:0] MaxV = AW'(sat_max(AW, SIGNED));
  localparam logic [AW-1:0] MinV = AW'(sat_min(AW, SIGNED));

  logic [2*DW-1:0] w_ext;
  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] prod;
  logic [AW:0]     p_ext;
  logic [AW:0]     acc_ext;
  logic [AW:0]     sum;

  // Low 2*DW bits of the product of extended operands equal the true product.
  assign w_ext   = {{DW{SIGNED & w[DW-1]}}, w};
  assign a_ext   = {{DW{SIGNED & a[DW-1]}}, a};
  assign prod    = w_ext * a_ext;
  assign p_ext   = (AW + 1)'(ext_prod(64'(prod), 2 * DW, SIGNED));
  // One extra bit of headroom makes overflow visible before clamping.
  assign acc_ext = clear ? '0 : {SIGNED & acc[AW-1], acc};
  assign sum     = acc_ext + p_ext;

  // Clamp or wrap the AW+1-bit sum back into the accumulator range.
  always_comb begin
    next_acc = sum[AW-1:0];
    clamped  = 1'b0;
    if (SAT) begin
      if (SIGNED) begin
        if (sum[AW] != sum[AW-1]) begin
          clamped  = 1'b1;
          next_acc = sum[AW] ? MinV : MaxV;
        end
      end else if (sum[AW]) begin
        // Products are non-negative, so unsigned overflow is always upward.
        clamped  = 1'b1;
        next_acc = MaxV;
      end
    end
  end

endmodule

// File: rtl/pe_mac_param.sv
// Output-stationary systolic PE: operand pass-through, burst accumulator and
// a one-entry result buffer drained over a valid/ready port.
module pe_mac_param
  import pe_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 32,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fire,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] a,
  output logic          out_f,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_w,
  output logic [AW-1:0] out,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          sat,
  output logic          drop
);

  state_t        state;
  logic [AW-1:0] acc;
  logic          sat_acc;
  logic [AW-1:0] next_acc;
  logic          clamped;
  logic          take;

  assign take = out_vld & out_rdy;

  pe_mac_unit #(
    .DW     (DW),
    .AW     (AW),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .acc      (acc),
    .w        (w),
    .a        (a),
    .clear    (state == IDLE),
    .next_acc (next_acc),
    .clamped  (clamped)
  );

  // Forward operands to the neighbouring PE regardless of state or backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_f <= 1'b0;
      out_a <= '0;
      out_w <= '0;
    end else begin
      out_f <= fire;
      out_a <= a;
      out_w <= w;
    end
  end

  // Accumulator FSM with result commit, drop pulse and drain handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      acc     <= '0;
      sat_acc <= 1'b0;
      out     <= '0;
      out_vld <= 1'b0;
      sat     <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (take) out_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fire) begin
            state   <= ACC;
            acc     <= next_acc;
            sat_acc <= clamped;
          end
        end
        ACC: begin
          if (fire) begin
            acc     <= next_acc;
            sat_acc <= sat_acc | clamped;
          end else begin
            state <= IDLE;
            // A buffer being drained this cycle counts as free.
            if (!out_vld || out_rdy) begin
              out     <= acc;
              sat     <= sat_acc;
              out_vld <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_mac_param.md
# pe_mac_param

Parametrised output-stationary processing element for the systolic array: the next generation of the fixed 8-bit PE. It multiplies the incoming weight and activation each fired cycle and accumulates across a burst. It forwards `w`, `a` and `fire` one cycle later to the neighbouring PE. It adds signed/unsigned mode, optional saturation, and a valid/ready drain port with a result buffer, so a new burst can start while the previous result waits to be collected.

## Interface
- `DW`, 8: width of weight and activation operands.
- `AW`, 32: accumulator/result width; must be ≥ 2*DW.
- `SIGNED`, 0: 1 = two's-complement operands and accumulator; 0 = unsigned.
- `SAT`, 1: 1 = clamp accumulator at AW-bit limits; 0 = wrap modulo 2^AW.
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  asynchronous active-low reset.
- `fire`  in  1  operand-valid; a contiguous high run is one accumulation burst.
- `w`  in  DW  weight operand.
- `a`  in  DW  activation operand.
- `out_f`  out  1  registered `fire`.
- `out_a`  out  DW  registered `a`.
- `out_w`  out  DW  registered `w`.
- `out`  out  AW  buffered burst result.
- `out_vld`  out  1  `out` holds an uncollected result.
- `out_rdy`  in  1  consumer accepts `out` when `out_vld && out_rdy`.
- `sat`  out  1  result in `out` was clamped (SAT=1 only, else tied 0).
- `drop`  out  1  one-cycle pulse: a burst result was discarded because the buffer was full.

## Operation
- Reset (async, rstn=0): `out_f`, `out_a`, `out_w`, `out`, `out_vld`, `sat`, `drop`, accumulator and state all 0; state IDLE.
- Pass-through: every edge, `out_f<=fire`, `out_a<=a`, `out_w<=w`, independent of state and backpressure.
- Accumulator FSM:
  - IDLE --fire=1--> ACC, with `acc <= 0 + p`.
  - ACC --fire=1--> ACC, with `acc <= acc + p`.
  - ACC --fire=0--> IDLE, with a result commit.
  - The first fired cycle always clears, so no explicit clear is needed.
  - A single-cycle burst is legal.
- Product `p = w*a`, 2*DW bits, sign-extended (SIGNED=1) or zero-extended to AW+1 bits before the add.
- SAT=1: the sum is clamped to [−2^(AW−1), 2^(AW−1)−1] if signed, or [0, 2^AW−1] if unsigned. An internal sticky `sat_acc` is set on any clamp in the burst and cleared on the burst's first cycle.
- SAT=0: the sum is truncated to AW bits.
- Commit, on the ACC→IDLE edge:
  - If the buffer is empty, or is being drained this same cycle (`out_vld && out_rdy`): `out<=acc`, `sat<=sat_acc`, `out_vld<=1`.
  - Otherwise the old result is kept and `drop` pulses high for one cycle.
- Drain: `out_vld && out_rdy` with no commit gives `out_vld<=0`; `out` and `sat` hold their last value.
- `fire` rising in the same cycle a commit happens is impossible: at least one fire=0 cycle separates bursts by definition.

## Timing
- Pass-through latency: 1 cycle.
- Burst of N fired cycles sampled at edges k..k+N−1:
  - fire=0 is sampled at edge k+N.
  - `out`/`out_vld` are valid after edge k+N.
  - Commit latency is 1 cycle after the last operand.
- MAC is single-cycle (combinational multiply-add-clamp into the register); no internal pipeline.
- `out_rdy` may be high with `out_vld` low; this has no effect.
- Reset mid-burst: accumulator discarded; no commit, no `drop`; IDLE on rstn release.
- Back-to-back bursts separated by one idle cycle: the second burst accumulates while the first result is held.

## Structure
- Package `pe_pkg`:
  - state enum {IDLE, ACC};
  - functions `sat_max(AW,SIGNED)` / `sat_min(AW,SIGNED)`;
  - function `ext_prod` for sign/zero extension.
- Sub-module `pe_mac_unit`: combinational extend-multiply-add-clamp. Inputs acc, w, a, clear. Outputs next_acc, clamped. Parametrised by DW/AW/SIGNED/SAT.
- Top holds pass-through registers, FSM, accumulator, result buffer and handshake.

## Test plan
- Default params, a=1, fire high 16 cycles with w=1..16, out_rdy=1 → `out`=136 (0x88), `out_vld` high one cycle after the last operand, `sat`=0.
- SIGNED=1, a=0xFF (−1), w=1..16 → `out`=0xFFFFFF78 (−136).
- SIGNED=0, AW=16, SAT=1, w=a=255 for 2 cycles → `out`=0xFFFF, `sat`=1. Same with SAT=0 → `out`=0xFC02 (130050 mod 65536), `sat`=0.
- Backpressure, out_rdy=0: burst w=a=2 (4 cycles) → `out`=16, `out_vld`=1. Then a second burst w=a=3 (2 cycles) → `drop` pulses once and `out` stays 16. Then raise out_rdy on the exact commit cycle of a third burst w=a=1 (1 cycle) → `out`=1, `out_vld` stays 1.
- Reset asserted on the 3rd cycle of a burst → all outputs 0 asynchronously. After release, burst w=a=1 for 2 cycles → `out`=2.
- Pass-through: random `w`/`a`/`fire` for 50 cycles → `out_w`/`out_a`/`out_f` equal the inputs delayed exactly one cycle, regardless of `out_rdy`.
